frame_assembler: RTL and testbench
==================================

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 SHALL have parameter ADC_WORDS, default 65: ADC samples per frame.
REQ-002 SHALL have parameter AUX_WORDS, default 3: auxiliary words per frame (taho1, taho2, impuls).
REQ-003 SHALL have parameter DIG_CH, default 6: number of digital (RZ) channels.
REQ-004 SHALL have parameter DIG_WORDS, default 32: words read per digital channel; power of 2.
REQ-005 SHALL have parameter AW, default 9: frame RAM address width per bank.
REQ-006 SHALL have parameter DW, default 16: data word width.
REQ-007 SHALL have port clock, input, 1: system clock, all logic on posedge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port sec, input, 1: single-cycle frame start strobe.
REQ-010 SHALL have port sample_rdy, input, 1: level; ADC sample valid while high.
REQ-011 SHALL have port adc_sample, input, DW: ADC sample data.
REQ-012 SHALL have port aux_data, input, AUX_WORDS*DW: packed aux words, word 0 in LSBs.
REQ-013 SHALL have port dig_ch_sel, output, clog2(DIG_CH): selected digital channel.
REQ-014 SHALL have port dig_rd_addr, output, clog2(DIG_WORDS): word address into selected channel buffer.
REQ-015 SHALL have port dig_data, input, DW: channel buffer data, valid 1 cycle after dig_ch_sel/dig_rd_addr change.
REQ-016 SHALL have port rd_addr, input, AW: external frame RAM read address.
REQ-017 SHALL have port q, output, DW: frame RAM read data, 1-cycle registered latency.
REQ-018 SHALL have ports frame_busy (output, 1: frame in progress), frame_done (output, 1: one-cycle pulse at frame end), overrun (output, 1: sticky) and frame_cnt (output, 16: completed-frame count).

Function
REQ-019 SHALL store frame layout: ADC words at 0..ADC_WORDS-1, aux at ADC_WORDS..ADC_WORDS+AUX_WORDS-1, then channel c word w at ADC_WORDS+AUX_WORDS+c*DIG_WORDS+w.
REQ-020 SHALL fail elaboration if frame length ADC_WORDS+AUX_WORDS+DIG_CH*DIG_WORDS exceeds 2^AW.
REQ-021 SHALL implement states IDLE, ADC_WAIT, ADC_LOW, AUX, DIG_ADDR, DIG_WR, DONE.
REQ-022 IDLE: sec=1 -> ADC_WAIT; write pointer and word counters cleared; frame_busy=1 from the next cycle.
REQ-023 ADC_WAIT: sample_rdy=1 -> write adc_sample at pointer next cycle, go ADC_LOW; a sample_rdy already high on entry is accepted.
REQ-024 ADC_LOW: wait for sample_rdy=0; then ADC_WAIT, or AUX after ADC_WORDS captures; exactly one capture per sample_rdy high period.
REQ-025 AUX: write one aux word per cycle, AUX_WORDS cycles, then DIG_ADDR.
REQ-026 DIG_ADDR drives dig_ch_sel/dig_rd_addr; DIG_WR writes dig_data next cycle: 2 cycles per digital word; channel order 0..DIG_CH-1, words 0..DIG_WORDS-1.
REQ-027 After the last digital write SHALL enter DONE, pulse frame_done for 1 cycle, increment frame_cnt (wraps 0xFFFF->0x0000), then go to IDLE.
REQ-028 sec in DONE SHALL start the next frame directly (to ADC_WAIT), without setting overrun.
REQ-029 sec in ADC_WAIT, ADC_LOW, AUX, DIG_ADDR or DIG_WR SHALL be ignored and SHALL set overrun; only reset clears overrun.
REQ-030 At most one RAM write per cycle; no write occurs in IDLE or DONE.
REQ-031 External reads SHALL be permitted on any cycle, concurrent with writes.

Reset
REQ-032 Reset SHALL force IDLE and clear frame_busy, frame_done, overrun, frame_cnt, dig_ch_sel and dig_rd_addr to 0.
REQ-033 Reset mid-frame SHALL abandon the partial frame without incrementing frame_cnt; RAM contents are not cleared.
REQ-034 q after reset is undefined until the first read cycle completes.

Configuration
REQ-035 With FRAME_ASM_PINGPONG_EN defined: RAM SHALL be 2*2^AW words, output bank (1 bit, reset 0) added; writes go to bank, reads use !bank; bank toggles at frame_done.
REQ-036 Without FRAME_ASM_PINGPONG_EN: single 2^AW-word bank, no bank port; reads see the frame being written.

Verification
REQ-037 sec, 65 sample_rdy pulses (data 0x1000+n), aux 0xA001/0xA002/0xA003, dig_data={ch,w} -> addr 0..64=0x1000..0x1040, 65..67=aux, 68+c*32+w={c,w}, one frame_done, frame_cnt=1.
REQ-038 sample_rdy held high 10 cycles -> one ADC word written.
REQ-039 sec at ADC sample 20 -> overrun=1, frame completes normally, frame_cnt=1.
REQ-040 reset asserted during DIG_WR of channel 3 -> IDLE, frame_cnt=0, frame_busy=0; next sec gives a complete frame.
REQ-041 PINGPONG_EN: two frames -> bank 0->1->0; frame 1 readable from bank 0 while frame 2 is written.
REQ-042 Preload frame_cnt path with 0xFFFF completed frames (forced) -> next frame_done gives frame_cnt=0x0000.

Source files
------------

// File: rtl/frame_assembler.sv
// frame_assembler: assembles ADC samples, aux words and digital channel words into a frame RAM.
// Optional double-buffered RAM with bank output: define FRAME_ASM_PINGPONG_EN.
module frame_assembler #(
    parameter int ADC_WORDS = 65,
    parameter int AUX_WORDS = 3,
    parameter int DIG_CH    = 6,
    parameter int DIG_WORDS = 32,
    parameter int AW        = 9,
    parameter int DW        = 16,
    localparam int CW = (DIG_CH > 1) ? $clog2(DIG_CH) : 1,
    localparam int WW = (DIG_WORDS > 1) ? $clog2(DIG_WORDS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sec,
    input  logic                    sample_rdy,
    input  logic [DW-1:0]           adc_sample,
    input  logic [AUX_WORDS*DW-1:0] aux_data,
    output logic [CW-1:0]           dig_ch_sel,
    output logic [WW-1:0]           dig_rd_addr,
    input  logic [DW-1:0]           dig_data,
    input  logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           q,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic                    overrun,
    output logic [15:0]             frame_cnt,
`ifdef FRAME_ASM_PINGPONG_EN
    output logic                    bank,
`endif
    output logic [2:0]              state_dbg
);
    localparam int FRAME_LEN = ADC_WORDS + AUX_WORDS + DIG_CH * DIG_WORDS;
    localparam int ACW = $clog2(ADC_WORDS + 1);
    localparam int XCW = $clog2(AUX_WORDS + 1);

    generate
        if (FRAME_LEN > (1 << AW)) begin : g_len_check
            $error("frame_assembler: frame length exceeds RAM bank size");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADC_WAIT = 3'd1,
        ADC_LOW  = 3'd2,
        AUX      = 3'd3,
        DIG_ADDR = 3'd4,
        DIG_WR   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t         state;
    logic [AW-1:0]  wr_ptr;
    logic [ACW-1:0] adc_cnt;
    logic [XCW-1:0] aux_cnt;
    logic           last_word;
    logic           last_dig;
    logic           frame_start;
    logic           sec_ignored;

    assign state_dbg   = state;
    assign last_word   = (dig_rd_addr == WW'(DIG_WORDS - 1));
    assign last_dig    = last_word && (dig_ch_sel == CW'(DIG_CH - 1));
    assign frame_start = sec && (state == IDLE || state == DONE);
    assign sec_ignored = sec && !(state == IDLE || state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            adc_cnt     <= '0;
            aux_cnt     <= '0;
            dig_ch_sel  <= '0;
            dig_rd_addr <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (sec_ignored)
                overrun <= 1'b1;
            if (frame_start) begin
                // A strobe in DONE chains straight into the next frame.
                state       <= ADC_WAIT;
                wr_ptr      <= '0;
                adc_cnt     <= '0;
                aux_cnt     <= '0;
                dig_ch_sel  <= '0;
                dig_rd_addr <= '0;
                frame_busy  <= 1'b1;
            end else begin
                case (state)
                    ADC_WAIT: if (sample_rdy) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        adc_cnt <= adc_cnt + 1'b1;
                        state   <= ADC_LOW;
                    end
                    ADC_LOW: if (!sample_rdy)
                        state <= (adc_cnt == ACW'(ADC_WORDS)) ? AUX : ADC_WAIT;
                    AUX: begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        aux_cnt <= aux_cnt + 1'b1;
                        if (aux_cnt == XCW'(AUX_WORDS - 1))
                            state <= DIG_ADDR;
                    end
                    DIG_ADDR: state <= DIG_WR;
                    DIG_WR: begin
                        // Address advances here so the buffer has a full DIG_ADDR cycle to respond.
                        wr_ptr <= wr_ptr + 1'b1;
                        if (last_dig) begin
                            dig_ch_sel  <= '0;
                            dig_rd_addr <= '0;
                            frame_done  <= 1'b1;
                            frame_cnt   <= frame_cnt + 16'd1;
                            state       <= DONE;
                        end else begin
                            dig_rd_addr <= last_word ? '0 : dig_rd_addr + 1'b1;
                            if (last_word)
                                dig_ch_sel <= dig_ch_sel + 1'b1;
                            state <= DIG_ADDR;
                        end
                    end
                    DONE: begin
                        state      <= IDLE;
                        frame_busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [DW-1:0] aux_word;
    logic [DW-1:0] wr_data;
    logic          wr_en;

    always_comb begin
        aux_word = aux_data[DW-1:0];
        for (int i = 0; i < AUX_WORDS; i++)
            if (aux_cnt == XCW'(i))
                aux_word = aux_data[i*DW +: DW];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = adc_sample;
        case (state)
            ADC_WAIT: wr_en = sample_rdy;
            AUX: begin
                wr_en   = 1'b1;
                wr_data = aux_word;
            end
            DIG_WR: begin
                wr_en   = 1'b1;
                wr_data = dig_data;
            end
            default: wr_en = 1'b0;
        endcase
    end

`ifdef FRAME_ASM_PINGPONG_EN
    localparam int MAW = AW + 1;
    logic [MAW-1:0] wr_addr;
    logic [MAW-1:0] rd_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bank <= 1'b0;
        else if (state == DIG_WR && last_dig && !frame_start)
            bank <= ~bank;
    end

    assign wr_addr = {bank, wr_ptr};
    assign rd_full = {~bank, rd_addr};
`else
    localparam int MAW = AW;
    logic [MAW-1:0] wr_addr;
    logic [MAW-1:0] rd_full;

    assign wr_addr = wr_ptr;
    assign rd_full = rd_addr;
`endif

    logic [DW-1:0] mem [0:(1 << MAW) - 1];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        q <= mem[rd_full];
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler: directed address table plus randomized frames
// compared against a layout model of the expected frame.
module tb_frame_assembler;
    localparam int ADC_WORDS = 65;
    localparam int AUX_WORDS = 3;
    localparam int DIG_CH    = 6;
    localparam int DIG_WORDS = 32;
    localparam int AW        = 9;
    localparam int DW        = 16;
    localparam int BASE      = ADC_WORDS + AUX_WORDS;
    localparam int FRAME_LEN = BASE + DIG_CH * DIG_WORDS;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ADC_WAIT = 3'd1, ST_ADC_LOW = 3'd2, ST_DIG_WR = 3'd5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    sec = 1'b0;
    logic                    sample_rdy = 1'b0;
    logic [DW-1:0]           adc_sample = '0;
    logic [AUX_WORDS*DW-1:0] aux_data = '0;
    logic [2:0]              dig_ch_sel;
    logic [4:0]              dig_rd_addr;
    logic [DW-1:0]           dig_data;
    logic [AW-1:0]           rd_addr = '0;
    logic [DW-1:0]           q;
    logic                    frame_busy, frame_done, overrun;
    logic [15:0]             frame_cnt;
    logic [2:0]              state_dbg;
`ifdef FRAME_ASM_PINGPONG_EN
    logic                    bank;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] adc_vals [ADC_WORDS];
    logic [DW-1:0] aux_vals [AUX_WORDS];
    logic [DW-1:0] dig_buf  [DIG_CH][DIG_WORDS];

    frame_assembler dut (
        .clock(clock), .reset(reset), .sec(sec), .sample_rdy(sample_rdy),
        .adc_sample(adc_sample), .aux_data(aux_data), .dig_ch_sel(dig_ch_sel),
        .dig_rd_addr(dig_rd_addr), .dig_data(dig_data), .rd_addr(rd_addr), .q(q),
        .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
        .frame_cnt(frame_cnt),
`ifdef FRAME_ASM_PINGPONG_EN
        .bank(bank),
`endif
        .state_dbg(state_dbg)
    );

    // clock / channel buffer with one-cycle registered read
    always #5 clock = ~clock;

    always @(posedge clock)
        dig_data <= (dig_ch_sel < DIG_CH) ? dig_buf[dig_ch_sel][dig_rd_addr] : '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic fill_stim(input bit directed);
        for (int n = 0; n < ADC_WORDS; n++)
            adc_vals[n] = directed ? DW'(16'h1000 + n) : DW'($urandom);
        for (int i = 0; i < AUX_WORDS; i++) begin
            aux_vals[i] = directed ? DW'(16'hA001 + i) : DW'($urandom);
            aux_data[i*DW +: DW] = aux_vals[i];
        end
        for (int c = 0; c < DIG_CH; c++)
            for (int w = 0; w < DIG_WORDS; w++)
                dig_buf[c][w] = directed ? DW'((c << 8) | w) : DW'($urandom);
    endtask

    // reference model: frame word by position in the layout
    function automatic logic [DW-1:0] exp_word(input int a);
        if (a < ADC_WORDS) return adc_vals[a];
        if (a < BASE) return aux_vals[a - ADC_WORDS];
        return dig_buf[(a - BASE) / DIG_WORDS][(a - BASE) % DIG_WORDS];
    endfunction

    task automatic start_frame();
        sec = 1'b1;
        tick();
        sec = 1'b0;
    endtask

    task automatic run_adc(input int sec_at, input int hold_first, input bit rnd);
        for (int n = 0; n < ADC_WORDS; n++) begin
            int h, l;
            h = rnd ? int'($urandom_range(1, 3)) : 1;
            l = rnd ? int'($urandom_range(1, 3)) : 1;
            if (n == 0 && hold_first > 0) h = hold_first;
            sample_rdy = 1'b1;
            adc_sample = adc_vals[n];
            if (n == sec_at) sec = 1'b1;
            for (int i = 0; i < h; i++) begin
                tick();
                sec = 1'b0;
            end
            if (n == 0 && hold_first > 0)
                check("held_rdy_state", state_dbg, ST_ADC_LOW);
            sample_rdy = 1'b0;
            adc_sample = DW'($urandom);
            repeat (l) tick();
        end
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done_seen"}, seen, 1'b1);
    endtask

    task automatic compare_frame(input string tag);
        logic [DW-1:0] exp_q [$];
        for (int a = 0; a < FRAME_LEN; a++)
            exp_q.push_back(exp_word(a));
        for (int a = 0; a < FRAME_LEN; a++) begin
            rd_addr = AW'(a);
            tick();
            check($sformatf("%s_word%0d", tag, a), q, exp_q.pop_front());
        end
    endtask

    initial begin
        vecs[0]  = '{9'd0,   16'h1000};
        vecs[1]  = '{9'd1,   16'h1001};
        vecs[2]  = '{9'd64,  16'h1040};
        vecs[3]  = '{9'd65,  16'hA001};
        vecs[4]  = '{9'd66,  16'hA002};
        vecs[5]  = '{9'd67,  16'hA003};
        vecs[6]  = '{9'd68,  16'h0000};
        vecs[7]  = '{9'd69,  16'h0001};
        vecs[8]  = '{9'd99,  16'h001F};
        vecs[9]  = '{9'd100, 16'h0100};
        vecs[10] = '{9'd169, 16'h0305};
        vecs[11] = '{9'd259, 16'h051F};

        fill_stim(1'b1);
        reset_dut();
        check("rst_busy", frame_busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        check("rst_ch_sel", dig_ch_sel, 3'd0);
        check("rst_rd_addr", dig_rd_addr, 5'd0);
        check("rst_state", state_dbg, ST_IDLE);

        // directed frame with known contents
        start_frame();
        check("start_busy", frame_busy, 1'b1);
        check("start_state", state_dbg, ST_ADC_WAIT);
        run_adc(-1, 0, 1'b0);
        wait_frame_done("dir");
        check("dir_frame_cnt", frame_cnt, 16'd1);
        tick();
        check("dir_done_pulse", frame_done, 1'b0);
        check("dir_idle_busy", frame_busy, 1'b0);
        check("dir_idle_state", state_dbg, ST_IDLE);
        check("dir_overrun", overrun, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rd_addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), q, vecs[i].exp);
        end
        compare_frame("dir");

        // sample_rdy held high: only one capture
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 10, 1'b1);
        wait_frame_done("hold");
        tick();
        check("hold_frame_cnt", frame_cnt, 16'd2);
        compare_frame("hold");

        // sec during DONE chains into the next frame without overrun
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 0, 1'b1);
        wait_frame_done("chain1");
        sec = 1'b1;
        tick();
        sec = 1'b0;
        check("chain_state", state_dbg, ST_ADC_WAIT);
        check("chain_busy", frame_busy, 1'b1);
        check("chain_overrun", overrun, 1'b0);
        check("chain_cnt1", frame_cnt, 16'd3);
        fill_stim(1'b0);
        run_adc(-1, 0, 1'b1);
        wait_frame_done("chain2");
        tick();
        check("chain_cnt2", frame_cnt, 16'd4);
        compare_frame("chain2");

        // sec mid-frame: ignored, sticky overrun
        reset_dut();
        check("ovr_rst_cnt", frame_cnt, 16'd0);
        fill_stim(1'b0);
        start_frame();
        run_adc(20, 0, 1'b1);
        check("ovr_set", overrun, 1'b1);
        wait_frame_done("ovr");
        tick();
        check("ovr_frame_cnt", frame_cnt, 16'd1);
        check("ovr_sticky", overrun, 1'b1);
        compare_frame("ovr");

        // asynchronous reset during a channel-3 digital write
        reset_dut();
        check("abort_overrun_cleared", overrun, 1'b0);
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 0, 1'b1);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (state_dbg == ST_DIG_WR && dig_ch_sel == 3'd3) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check("abort_reached_ch3", found, 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_busy", frame_busy, 1'b0);
        check("abort_frame_cnt", frame_cnt, 16'd0);
        tick();
        reset = 1'b0;
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 0, 1'b1);
        wait_frame_done("after_abort");
        tick();
        check("after_abort_cnt", frame_cnt, 16'd1);
        compare_frame("after_abort");

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        check("wrap_preload", frame_cnt, 16'hFFFF);
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 0, 1'b1);
        wait_frame_done("wrap");
        check("wrap_cnt", frame_cnt, 16'h0000);
        tick();

`ifdef FRAME_ASM_PINGPONG_EN
        reset_dut();
        check("pp_bank_rst", bank, 1'b0);
        fill_stim(1'b0);
        start_frame();
        run_adc(-1, 0, 1'b1);
        wait_frame_done("pp1");
        check("pp_bank_after1", bank, 1'b1);
        tick();
        start_frame();
        compare_frame("pp1_during2");
        fill_stim(1'b0);
        run_adc(-1, 0, 1'b1);
        wait_frame_done("pp2");
        check("pp_bank_after2", bank, 1'b0);
        tick();
        compare_frame("pp2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
